// File: rtl/tile_cfg_bank_loader.sv
// Tile configuration loader: assembles BL_W-bit bitline rows from DIN_W-bit chunks
// and programs WL_W rows in order, pulsing one wordline per row.
module tile_cfg_bank_loader #(
    parameter int BL_W     = 315,
    parameter int WL_W     = 4,
    parameter int DIN_W    = 35,
    parameter int WL_PULSE = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DIN_W-1:0]          din,
    input  logic                      din_valid,
    output logic                      din_ready,
    output logic [BL_W-1:0]           bl_out,
    output logic [WL_W-1:0]           wl_out,
    output logic [$clog2(WL_W)-1:0]   row_idx,
    output logic                      busy,
    output logic                      done
);

    localparam int CHUNKS = BL_W / DIN_W;
    localparam int RW     = $clog2(WL_W);
    localparam int CNT_W  = $clog2(CHUNKS + 1);
    localparam int PW     = $clog2(WL_PULSE + 1);
    localparam int OW     = $clog2(BL_W);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETUP, S_PULSE, S_HOLD, S_DONE
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [RW-1:0]    r_row, w_row_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [PW-1:0]    r_pcnt, w_pcnt_nxt;
    logic [BL_W-1:0]  r_shadow, r_bl, w_merged;
    logic [OW-1:0]    w_ofs;
    logic [WL_W-1:0]  r_wl, w_wl_nxt;
    logic             r_din_ready, r_busy, r_done;
    logic             w_xfer, w_last_chunk, w_last_row;

    // Next-state, counters and the shadow row with the incoming chunk merged in.
    always_comb begin
        w_state_nxt  = r_state;
        w_row_nxt    = r_row;
        w_cnt_nxt    = r_cnt;
        w_pcnt_nxt   = r_pcnt;
        w_merged     = r_shadow;
        w_ofs        = OW'(r_cnt * DIN_W);
        w_xfer       = r_din_ready && din_valid;
        w_last_chunk = (r_cnt == CNT_W'(CHUNKS - 1));
        w_last_row   = (r_row == RW'(WL_W - 1));

        // The counter only addresses a valid chunk slot while loading.
        if (r_state == S_LOAD) begin
            w_merged[w_ofs +: DIN_W] = din;
        end else begin
            w_merged = r_shadow;
        end

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_row_nxt   = {RW{1'b0}};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (w_last_chunk) begin
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_PULSE;
                w_pcnt_nxt  = {PW{1'b0}};
            end
            S_PULSE: begin
                if (r_pcnt == PW'(WL_PULSE - 1)) begin
                    w_state_nxt = S_HOLD;
                end else begin
                    w_pcnt_nxt = r_pcnt + PW'(1);
                end
            end
            S_HOLD: begin
                if (w_last_row) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_LOAD;
                    w_row_nxt   = r_row + RW'(1);
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_state_nxt == S_PULSE) begin
            w_wl_nxt = WL_W'(1'b1) << w_row_nxt;
        end else begin
            w_wl_nxt = {WL_W{1'b0}};
        end
    end

    // State and sequencing counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_row   <= {RW{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_pcnt  <= {PW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pcnt  <= w_pcnt_nxt;
        end
    end

    // Registered outputs decoded from the next state; bl_out latches only on a completed row.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow    <= {BL_W{1'b0}};
            r_bl        <= {BL_W{1'b0}};
            r_wl        <= {WL_W{1'b0}};
            r_din_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_shadow <= w_merged;
            end
            if (w_xfer && w_last_chunk) begin
                r_bl <= w_merged;
            end
            r_wl        <= w_wl_nxt;
            r_din_ready <= (w_state_nxt == S_LOAD);
            r_busy      <= (w_state_nxt == S_LOAD) || (w_state_nxt == S_SETUP) ||
                           (w_state_nxt == S_PULSE) || (w_state_nxt == S_HOLD);
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    assign din_ready = r_din_ready;
    assign bl_out    = r_bl;
    assign wl_out    = r_wl;
    assign row_idx   = r_row;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: doc/tile_cfg_bank_loader.md
Name: tile_cfg_bank_loader

Overview:
- Memory-bank configuration sequencer for one tile.
- Accepts a configuration stream in DIN_W-bit chunks over a valid/ready handshake and assembles one BL_W-bit bitline row at a time.
- Writes each row by pulsing one wordline of a one-hot wordline bus; rows 0..WL_W-1 are programmed in order.
- Default geometry: 315 bitlines x 4 wordlines, matching the tile's 1260-bit bl/wl configuration space (grid_clb + cbx + cby + sb).

Parameters:
- BL_W, 315, bitlines per row; BL_W % DIN_W must be 0.
- WL_W, 4, wordlines (rows) per tile.
- DIN_W, 35, chunk width; CHUNKS = BL_W/DIN_W, default 9.
- WL_PULSE, 2, cycles each wordline is held high, >=1.

Ports:
- clk, input, 1, single clock, all state on rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, single-cycle request to begin a full tile load.
- din, input, DIN_W, configuration chunk.
- din_valid, input, 1, chunk valid.
- din_ready, output, 1, loader accepts a chunk this cycle.
- bl_out, output, BL_W, bitline data to the tile bl chain.
- wl_out, output, WL_W, one-hot wordline strobe.
- row_idx, output, clog2(WL_W), row currently being loaded or programmed.
- busy, output, 1, high from the cycle after an accepted start until done rises.
- done, output, 1, sticky; high after the last row is written, until the next start or reset.

Behaviour:
- Reset (sync, active-high) values: state IDLE; bl_out=0; wl_out=0; din_ready=0; busy=0; done=0; row_idx=0; chunk counter=0.
- Reset asserted mid-operation: wl_out is 0 from the next edge; the partial row is discarded.
- States: IDLE, LOAD, SETUP, PULSE, HOLD, DONE.
- IDLE/DONE, start=1:
  - Next state LOAD; row_idx=0; chunk counter=0.
  - done clears; busy sets.
  - start in any other state is ignored.
- LOAD:
  - din_ready=1.
  - A chunk transfers when din_valid & din_ready.
  - Chunk k (0-based) is written to shadow[k*DIN_W +: DIN_W]; the counter increments.
  - No transfer leaves state and counter unchanged; stalls are unlimited.
  - On transfer of chunk CHUNKS-1: next state SETUP; bl_out <= shadow with the final chunk merged, on the same edge.
- SETUP: 1 cycle; wl_out=0; bl_out stable.
- PULSE:
  - WL_PULSE cycles with wl_out = 1<<row_idx.
  - bl_out stable; din_ready=0.
- HOLD: 1 cycle; wl_out=0; bl_out stable.
  - If row_idx==WL_W-1: next state DONE; busy=0; done=1.
  - Else: row_idx+1; chunk counter=0; next state LOAD.
- bl_out changes only on the LOAD->SETUP edge or reset; it retains its last row in DONE.
- wl_out: never more than one bit set; only nonzero in PULSE.
- Throughput per row, with din_valid held high: CHUNKS + 2 + WL_PULSE cycles.
  - Full load, default parameters: 1 (start) + 4*13 = 53 cycles from start to done rising.
- din_valid outside LOAD: ignored; no data is consumed (din_ready=0).
- Counters saturate-free: the chunk counter wraps only via the explicit reset to 0 in HOLD.

Test Plan:
- Reset then idle: hold reset 3 cycles -> all outputs 0. Drive din_valid=1 with no start -> din_ready stays 0 and wl_out stays 0.
- Full load, no stalls: start, then 36 chunks with chunk value = index (0..35).
  - Row r: bl_out[35*k +: 35] = 9r+k.
  - wl_out = 0001, 0010, 0100, 1000, each high exactly 2 cycles.
  - done rises 53 cycles after start.
- Backpressure: deassert din_valid for 5 cycles after chunk 4 of row 1 -> row-1 pulse delayed by exactly 5 cycles; bl_out content unchanged versus the no-stall case.
- Spurious start: pulse start during row 2 PULSE -> ignored; sequence completes normally with done=1.
- Reset mid-PULSE of row 1: wl_out=0 the next cycle; busy=0. A new start plus 36 chunks then programs rows 0..3 from scratch.
- Restart after done: second start with all chunks = 35'h7FFFFFFFF -> done clears the cycle after start; bl_out all ones for every row; done reasserts after 53 cycles.
